div_bitstream_driver: RTL and testbench

Transmit-side counterpart of the divisibility checker. Accepts parallel words over a valid/ready handshake, serializes each word MSB-first onto the checker's `bitstream`/`bitstream_vld` inputs, and counts the checker's `result_vld` pulses. On the last bit of each word it returns the checker's `divisible` verdict through a valid/ready response port. It sits between the stimulus/host side and the checker, and shares the checker's clock and reset.

---
 rtl/div_bitstream_driver.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_div_bitstream_driver.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/div_bitstream_driver.sv
// -----------------------------------------------------------------------------
// div_bitstream_driver
//
// Transmit-side companion of the divisibility checker. A parallel word is
// accepted over a valid/ready handshake and shifted out MSB-first on
// bitstream/bitstream_vld. The checker's result_vld pulses are counted. Once
// every bit of the word has produced a result, the checker's divisible verdict
// is returned on a valid/ready response port. If the results do not arrive in
// time, the response is returned with out_err set.
//
// Parameters
//   WORD_W        maximum word length in bits
//   RESP_TIMEOUT  cycles to wait for outstanding results after the last bit
//   GAP           idle cycles between bits (only with DIV_DRV_GAP_EN)
//
// Configuration macro
//   DIV_DRV_GAP_EN  when defined, GAP idle cycles are inserted after every bit
//                   except the last. When undefined, bits go back-to-back and
//                   no gap counter exists.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_word, in_len   word and bit count (0 or >WORD_W means WORD_W)
//   in_vld, in_rdy    input handshake
//   bitstream(_vld)   serial bit to the checker and its qualifier
//   divisible         checker verdict
//   result_vld        qualifies divisible, one pulse per bit
//   out_divisible     verdict for the whole stream, sampled at the last bit
//   out_err           response timed out
//   out_vld, out_rdy  response handshake
// -----------------------------------------------------------------------------
module div_bitstream_driver #(
  parameter int unsigned WORD_W       = 16,
  parameter int unsigned RESP_TIMEOUT = 8,
  parameter int unsigned GAP          = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WORD_W-1:0]            in_word,
  input  logic [$clog2(WORD_W+1)-1:0]  in_len,
  input  logic                         in_vld,
  output logic                         in_rdy,
  output logic                         bitstream,
  output logic                         bitstream_vld,
  input  logic                         divisible,
  input  logic                         result_vld,
  output logic                         out_divisible,
  output logic                         out_err,
  output logic                         out_vld,
  input  logic                         out_rdy
);

  localparam int unsigned LW = $clog2(WORD_W + 1);
  localparam int unsigned TW = (RESP_TIMEOUT > 0) ? $clog2(RESP_TIMEOUT + 1) : 1;

  localparam logic [LW-1:0] ZERO_L  = {LW{1'b0}};
  localparam logic [LW-1:0] ONE_L   = LW'(1);
  localparam logic [LW-1:0] WORD_WL = LW'(WORD_W);
  localparam logic [TW-1:0] ZERO_T  = {TW{1'b0}};
  localparam logic [TW-1:0] TMO_SAT = TW'(RESP_TIMEOUT);
  localparam logic [TW:0]   TMO_LIM = (TW + 1)'(RESP_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RES = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t            state_r, state_nxt;
  logic [WORD_W-1:0] word_r, word_nxt;
  logic [LW-1:0]     len_r, len_nxt;
  logic [LW-1:0]     idx_r, idx_nxt;
  logic [LW-1:0]     cnt_r, cnt_nxt;
  logic [TW-1:0]     tmo_r, tmo_nxt;
  logic              bit_r, bit_nxt;
  logic              bit_vld_r, bit_vld_nxt;
  logic              in_rdy_r, in_rdy_nxt;
  logic              out_vld_r, out_vld_nxt;
  logic              out_div_r, out_div_nxt;
  logic              out_err_r, out_err_nxt;

`ifdef DIV_DRV_GAP_EN
  localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GW-1:0] ZERO_G = {GW{1'b0}};
  localparam logic [GW-1:0] ONE_G  = GW'(1);
  logic [GW-1:0]     gap_r, gap_nxt;
`endif

  logic [LW-1:0] len_clamp_s;
  logic [LW-1:0] first_idx_s;
  logic [LW-1:0] adv_idx_s;
  logic          first_bit_s;
  logic          adv_bit_s;
  logic          in_hs_s;
  logic          counting_s;
  logic          res_done_s;
  logic          last_bit_s;
  logic          tmo_hit_s;
  logic          out_hs_s;

  // Bit select with a width-matched index compare, so the index may be wider
  // than strictly needed to address the word.
  function automatic logic pick_bit(input logic [WORD_W-1:0] w, input logic [LW-1:0] i);
    logic b;
    b = 1'b0;
    for (int k = 0; k < WORD_W; k++) begin
      if (i == LW'(k)) begin
        b = w[k];
      end else begin
        b = b;
      end
    end
    return b;
  endfunction

  assign len_clamp_s = ((in_len == ZERO_L) || (in_len > WORD_WL)) ? WORD_WL : in_len;
  assign first_idx_s = len_clamp_s - ONE_L;
  assign first_bit_s = pick_bit(in_word, first_idx_s);
  assign adv_idx_s   = idx_r - ONE_L;
  assign adv_bit_s   = pick_bit(word_r, adv_idx_s);

  assign in_hs_s    = (state_r == IDLE) && in_vld;
  assign counting_s = (state_r == SEND) || (state_r == WAIT_RES);
  // Results can land in the same cycle as their bit, so completion is
  // evaluated in SEND as well as WAIT_RES.
  assign res_done_s = counting_s && result_vld && ((cnt_r + ONE_L) == len_r);
  assign last_bit_s = (state_r == SEND) && bit_vld_r && (idx_r == ZERO_L);
  assign tmo_hit_s  = (state_r == WAIT_RES) &&
                      (({1'b0, tmo_r} + {{TW{1'b0}}, 1'b1}) >= TMO_LIM);
  assign out_hs_s   = (state_r == RESP) && out_rdy;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      word_r    <= {WORD_W{1'b0}};
      len_r     <= ZERO_L;
      idx_r     <= ZERO_L;
      cnt_r     <= ZERO_L;
      tmo_r     <= ZERO_T;
      bit_r     <= 1'b0;
      bit_vld_r <= 1'b0;
      in_rdy_r  <= 1'b1;
      out_vld_r <= 1'b0;
      out_div_r <= 1'b0;
      out_err_r <= 1'b0;
`ifdef DIV_DRV_GAP_EN
      gap_r     <= ZERO_G;
`endif
    end else begin
      state_r   <= state_nxt;
      word_r    <= word_nxt;
      len_r     <= len_nxt;
      idx_r     <= idx_nxt;
      cnt_r     <= cnt_nxt;
      tmo_r     <= tmo_nxt;
      bit_r     <= bit_nxt;
      bit_vld_r <= bit_vld_nxt;
      in_rdy_r  <= in_rdy_nxt;
      out_vld_r <= out_vld_nxt;
      out_div_r <= out_div_nxt;
      out_err_r <= out_err_nxt;
`ifdef DIV_DRV_GAP_EN
      gap_r     <= gap_nxt;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (in_hs_s) state_nxt = SEND;
        else         state_nxt = IDLE;
      end
      SEND: begin
        if (res_done_s)      state_nxt = RESP;
        else if (last_bit_s) state_nxt = WAIT_RES;
        else                 state_nxt = SEND;
      end
      WAIT_RES: begin
        if (res_done_s || tmo_hit_s) state_nxt = RESP;
        else                         state_nxt = WAIT_RES;
      end
      RESP: begin
        if (out_hs_s) state_nxt = IDLE;
        else          state_nxt = RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath. bitstream_vld
  // defaults low, so it is only high in cycles that present a bit.
  always_comb begin
    word_nxt    = word_r;
    len_nxt     = len_r;
    idx_nxt     = idx_r;
    cnt_nxt     = cnt_r;
    tmo_nxt     = tmo_r;
    bit_nxt     = 1'b0;
    bit_vld_nxt = 1'b0;
    out_vld_nxt = out_vld_r;
    out_div_nxt = out_div_r;
    out_err_nxt = out_err_r;
`ifdef DIV_DRV_GAP_EN
    gap_nxt     = gap_r;
`endif
    case (state_r)
      IDLE: begin
        if (in_hs_s) begin
          word_nxt    = in_word;
          len_nxt     = len_clamp_s;
          idx_nxt     = first_idx_s;
          cnt_nxt     = ZERO_L;
          tmo_nxt     = ZERO_T;
          bit_nxt     = first_bit_s;
          bit_vld_nxt = 1'b1;
`ifdef DIV_DRV_GAP_EN
          gap_nxt     = ZERO_G;
`endif
        end else begin
          bit_vld_nxt = 1'b0;
        end
      end
      SEND: begin
        if (result_vld) cnt_nxt = cnt_r + ONE_L;
        else            cnt_nxt = cnt_r;
        if (res_done_s) begin
          out_vld_nxt = 1'b1;
          out_div_nxt = divisible;
          out_err_nxt = 1'b0;
        end else if (bit_vld_r) begin
          if (idx_r == ZERO_L) begin
            tmo_nxt = ZERO_T;
          end else begin
`ifdef DIV_DRV_GAP_EN
            if (GAP > 32'd0) begin
              gap_nxt = GW'(GAP);
            end else begin
              idx_nxt     = adv_idx_s;
              bit_nxt     = adv_bit_s;
              bit_vld_nxt = 1'b1;
            end
`else
            idx_nxt     = adv_idx_s;
            bit_nxt     = adv_bit_s;
            bit_vld_nxt = 1'b1;
`endif
          end
        end else begin
`ifdef DIV_DRV_GAP_EN
          // Gap cycle: the next bit goes out once the counter runs down.
          if (gap_r <= ONE_G) begin
            gap_nxt     = ZERO_G;
            idx_nxt     = adv_idx_s;
            bit_nxt     = adv_bit_s;
            bit_vld_nxt = 1'b1;
          end else begin
            gap_nxt = gap_r - ONE_G;
          end
`else
          bit_vld_nxt = 1'b0;
`endif
        end
      end
      WAIT_RES: begin
        if (result_vld) cnt_nxt = cnt_r + ONE_L;
        else            cnt_nxt = cnt_r;
        if (res_done_s) begin
          out_vld_nxt = 1'b1;
          out_div_nxt = divisible;
          out_err_nxt = 1'b0;
        end else if (tmo_hit_s) begin
          out_vld_nxt = 1'b1;
          out_div_nxt = 1'b0;
          out_err_nxt = 1'b1;
        end else if (tmo_r != TMO_SAT) begin
          tmo_nxt = tmo_r + TW'(1);
        end else begin
          tmo_nxt = tmo_r;
        end
      end
      RESP: begin
        if (out_rdy) begin
          out_vld_nxt = 1'b0;
          out_div_nxt = 1'b0;
          out_err_nxt = 1'b0;
        end else begin
          out_vld_nxt = 1'b1;
        end
      end
      default: begin
        out_vld_nxt = 1'b0;
        out_div_nxt = 1'b0;
        out_err_nxt = 1'b0;
      end
    endcase
    in_rdy_nxt = (state_nxt == IDLE);
  end

  assign in_rdy        = in_rdy_r;
  assign bitstream     = bit_r;
  assign bitstream_vld = bit_vld_r;
  assign out_vld       = out_vld_r;
  assign out_divisible = out_div_r;
  assign out_err       = out_err_r;

endmodule

// File: tb/tb_div_bitstream_driver.sv
// -----------------------------------------------------------------------------
// Directed testbench for div_bitstream_driver. A combinational divide-by-3
// checker model closes the loop; result_vld can be disabled to force timeouts.
// Expected values are hand-computed from the stream contents.
// -----------------------------------------------------------------------------
module tb_div_bitstream_driver;

`ifdef DIV_DRV_GAP_EN
  localparam int GAP_T = 2;
`else
  localparam int GAP_T = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_word;
  logic [4:0]  in_len;
  logic        in_vld;
  logic        in_rdy;
  logic        bitstream;
  logic        bitstream_vld;
  logic        divisible;
  logic        result_vld;
  logic        out_divisible;
  logic        out_err;
  logic        out_vld;
  logic        out_rdy;
  logic        chk_en;
  logic [1:0]  res;
  logic [1:0]  nres;

  int n_assert = 0;
  int n_fail   = 0;

  div_bitstream_driver #(.WORD_W(16), .RESP_TIMEOUT(8), .GAP(GAP_T)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_word       (in_word),
    .in_len        (in_len),
    .in_vld        (in_vld),
    .in_rdy        (in_rdy),
    .bitstream     (bitstream),
    .bitstream_vld (bitstream_vld),
    .divisible     (divisible),
    .result_vld    (result_vld),
    .out_divisible (out_divisible),
    .out_err       (out_err),
    .out_vld       (out_vld),
    .out_rdy       (out_rdy)
  );

  always #5 clk = ~clk;

  // Divide-by-3 checker: residue of the whole stream since reset.
  assign nres       = 2'(({1'b0, res, 1'b0} + {3'b000, bitstream}) % 4'd3);
  assign divisible  = (nres == 2'd0);
  assign result_vld = bitstream_vld & chk_en;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)             res <= 2'd0;
    else if (bitstream_vld) res <= nres;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Walk the first m of n bits of word w, checking value and gap cycles.
  task automatic expect_bits(input logic [15:0] w, input int n, input int m);
    for (int k = 0; k < m; k++) begin
      step();
      in_vld = 1'b0;
      chk("bit_vld", bitstream_vld, 1'b1);
      chk("bit_val", bitstream, w[n-1-k]);
      chk("busy_in_rdy", in_rdy, 1'b0);
      if (k < n - 1) begin
        for (int g = 0; g < GAP_T; g++) begin
          step();
          chk("gap_bit_vld", bitstream_vld, 1'b0);
        end
      end
    end
    if (m == n) step();
  endtask

  task automatic check_resp(input string tag, input logic div, input logic err);
    chk({tag, "_out_vld"}, out_vld, 1'b1);
    chk({tag, "_out_div"}, out_divisible, div);
    chk({tag, "_out_err"}, out_err, err);
    step();
    chk({tag, "_ret_in_rdy"}, in_rdy, 1'b1);
    chk({tag, "_ret_out_vld"}, out_vld, 1'b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    in_vld  = 1'b0;
    in_word = 16'h0000;
    in_len  = 5'd0;
    out_rdy = 1'b1;
    chk_en  = 1'b1;
    step();
    step();
    chk("rst_in_rdy", in_rdy, 1'b1);
    chk("rst_bit", bitstream, 1'b0);
    chk("rst_bit_vld", bitstream_vld, 1'b0);
    chk("rst_out_vld", out_vld, 1'b0);
    chk("rst_out_div", out_divisible, 1'b0);
    chk("rst_out_err", out_err, 1'b0);
    rst_n = 1'b1;
    step();

    // 110b: stream 6, divisible by 3
    in_word = 16'h0006; in_len = 5'd3; in_vld = 1'b1;
    expect_bits(16'h0006, 3, 3);
    check_resp("w6", 1'b1, 1'b0);

    // 1b appended: stream 13
    in_word = 16'h0001; in_len = 5'd1; in_vld = 1'b1;
    expect_bits(16'h0001, 1, 1);
    check_resp("w1", 1'b0, 1'b0);

    // len 0 -> 16 bits; residue 1 -> 0 -> 0.. -> 1
    in_word = 16'h8001; in_len = 5'd0; in_vld = 1'b1;
    expect_bits(16'h8001, 16, 16);
    check_resp("len0", 1'b0, 1'b0);

    // len 31 -> 16 bits; residue 1 -> ...zeros... -> 1 -> 0 -> 0
    in_word = 16'h0002; in_len = 5'd31; in_vld = 1'b1;
    expect_bits(16'h0002, 16, 16);
    check_resp("len31", 1'b1, 1'b0);

    // Timeout: no result pulses, response 9 cycles after the last bit
    chk_en  = 1'b0;
    in_word = 16'h000A; in_len = 5'd4; in_vld = 1'b1;
    expect_bits(16'h000A, 4, 4);
    out_rdy = 1'b0;
    in_word = 16'h0002; in_len = 5'd2; in_vld = 1'b1;
    chk("tmo_wait_vld", out_vld, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("tmo_wait_vld", out_vld, 1'b0);
      chk("tmo_wait_bit_vld", bitstream_vld, 1'b0);
    end
    step();
    chk("tmo_out_vld", out_vld, 1'b1);
    chk("tmo_out_err", out_err, 1'b1);
    chk("tmo_out_div", out_divisible, 1'b0);

    // Response stall with a pending input word
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_in_rdy", in_rdy, 1'b0);
      chk("stall_bit_vld", bitstream_vld, 1'b0);
      chk("stall_out_vld", out_vld, 1'b1);
      chk("stall_out_err", out_err, 1'b1);
      chk("stall_out_div", out_divisible, 1'b0);
    end
    out_rdy = 1'b1;
    chk_en  = 1'b1;
    step();
    chk("post_hs_in_rdy", in_rdy, 1'b1);
    chk("post_hs_out_vld", out_vld, 1'b0);
    // residue 1 (after 1010b): 1 -> 0 -> 0
    expect_bits(16'h0002, 2, 2);
    check_resp("after_stall", 1'b1, 1'b0);

    // Mid-word reset after the second bit
    in_word = 16'h00A5; in_len = 5'd8; in_vld = 1'b1;
    expect_bits(16'h00A5, 8, 2);
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_rdy", in_rdy, 1'b1);
    chk("mid_rst_bit", bitstream, 1'b0);
    chk("mid_rst_bit_vld", bitstream_vld, 1'b0);
    chk("mid_rst_out_vld", out_vld, 1'b0);
    chk("mid_rst_out_div", out_divisible, 1'b0);
    chk("mid_rst_out_err", out_err, 1'b0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("post_rst_in_rdy", in_rdy, 1'b1);
      chk("post_rst_bit_vld", bitstream_vld, 1'b0);
    end

    // Fresh stream after reset: 11b = 3
    in_word = 16'h0003; in_len = 5'd2; in_vld = 1'b1;
    expect_bits(16'h0003, 2, 2);
    check_resp("post_rst_word", 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
